// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: stage indices,
// stall-vector encodings and the divide sequencer state enum.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 5;

  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;

  // Thermometer encodings: holding a stage also holds every stage before it
  localparam logic [STALL_W-1:0] STALL_NONE = 5'b00000;
  localparam logic [STALL_W-1:0] STALL_IF   = 5'b00011;
  localparam logic [STALL_W-1:0] STALL_ID   = 5'b00111;
  localparam logic [STALL_W-1:0] STALL_EX   = 5'b01111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 5'b11111;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_DIV_BUSY = 1'b1
  } div_state_e;

endpackage

// File: rtl/div_seq_counter.sv
// Multi-cycle divide sequencer: holds EX until the final divide cycle and
// pulses div_done when the result is valid. Freezes while MEM is not ready.
module div_seq_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic div_start,
  input  logic mem_wait,
  output logic stall_ex_div,
  output logic div_busy,
  output logic div_done
);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // div_start while busy is the same divide still sitting in EX, so it is ignored
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (div_start && !mem_wait) begin
          w_state_nxt = ST_DIV_BUSY;
          w_cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
        end
      end
      ST_DIV_BUSY: begin
        if (!mem_wait) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (w_last) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign stall_ex_div = !reset &&
                        (((r_state == ST_IDLE) && div_start) ||
                         ((r_state == ST_DIV_BUSY) && !w_last));
  assign div_busy     = !reset && (r_state == ST_DIV_BUSY);
  assign div_done     = !reset && (r_state == ST_DIV_BUSY) && w_last && !mem_wait;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall/flush controller: priority-encodes stage requests
// into a thermometer stall vector and generates the branch flush.
// Optional performance counters are enabled with `define STALL_PERF_CNT_EN.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 4,
  parameter int unsigned CNT_W      = 4
`ifdef STALL_PERF_CNT_EN
  ,
  parameter int unsigned PERF_W     = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_if,
  input  logic               req_id_lu,
  input  logic               div_start,
  input  logic               mem_wait,
  input  logic               branch_taken_ex,
  output logic [STALL_W-1:0] stall,
  output logic               do_stall,
  output logic               flush_br,
  output logic               div_busy,
  output logic               div_done
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]  perf_stall_cyc,
  output logic [PERF_W-1:0]  perf_flush_cnt,
  output logic [PERF_W-1:0]  perf_div_cnt
`endif
);

  logic w_stall_ex_div;
  logic w_ex_held;
  logic w_lu_eff;

  div_seq_counter #(
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_div_seq (
    .clk          (clk),
    .reset        (reset),
    .div_start    (div_start),
    .mem_wait     (mem_wait),
    .stall_ex_div (w_stall_ex_div),
    .div_busy     (div_busy),
    .div_done     (div_done)
  );

  // EX hold is known before the load-use request, so the flush cannot loop back
  assign w_ex_held = mem_wait || w_stall_ex_div;
  assign flush_br  = !reset && branch_taken_ex && !w_ex_held;
  assign w_lu_eff  = req_id_lu && !flush_br;

  always_comb begin
    stall = STALL_NONE;
    if (reset) begin
      stall = STALL_NONE;
    end else if (mem_wait) begin
      stall = STALL_MEM;
    end else if (w_stall_ex_div) begin
      stall = STALL_EX;
    end else if (w_lu_eff) begin
      stall = STALL_ID;
    end else if (req_if) begin
      stall = STALL_IF;
    end
  end

  assign do_stall = |stall;

`ifdef STALL_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf_stall_cyc;
  logic [PERF_W-1:0] r_perf_flush_cnt;
  logic [PERF_W-1:0] r_perf_div_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall_cyc <= '0;
      r_perf_flush_cnt <= '0;
      r_perf_div_cnt   <= '0;
    end else begin
      if (do_stall) r_perf_stall_cyc <= r_perf_stall_cyc + PERF_W'(1);
      if (flush_br) r_perf_flush_cnt <= r_perf_flush_cnt + PERF_W'(1);
      if (div_done) r_perf_div_cnt   <= r_perf_div_cnt + PERF_W'(1);
    end
  end

  assign perf_stall_cyc = r_perf_stall_cyc;
  assign perf_flush_cnt = r_perf_flush_cnt;
  assign perf_div_cnt   = r_perf_div_cnt;
`endif

endmodule
